// File: rtl/aht10_pkg.sv
// Shared constants, FSM encoding and the double-dabble digit adjust for the
// AHT10 raw-to-BCD converter.
package aht10_pkg;

  localparam int unsigned RAW_W   = 20;
  localparam int unsigned SCALE_W = 11;
  localparam int unsigned PROD_W  = RAW_W + SCALE_W;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned HUM_W   = 12;
  localparam int unsigned CNT_W   = 4;

  localparam logic [SCALE_W-1:0] K_HUM     = 11'd1000;
  localparam logic [SCALE_W-1:0] K_TEM     = 11'd2000;
  localparam logic [SCALE_W:0]   T_OFFSET  = 12'd500;
  localparam logic [CNT_W-1:0]   LAST_STEP = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_H,
    ST_BCD_H,
    ST_MUL_T,
    ST_ADJ,
    ST_BCD_T,
    ST_DONE
  } state_t;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/aht10_data_conv_if.sv
// Raw sample input and BCD result bus between the sensor read controller,
// the converter and its display / UART consumers.
interface aht10_data_conv_if;
  import aht10_pkg::*;

  logic               raw_vld;
  logic [RAW_W-1:0]   hum_raw;
  logic [RAW_W-1:0]   tem_raw;
  logic               busy;
  logic [HUM_W-1:0]   hum_bcd;
  logic [BCD_W-1:0]   tem_bcd;
  logic               tem_neg;
  logic               dout_vld;

  modport master (
    output raw_vld, hum_raw, tem_raw,
    input  busy, hum_bcd, tem_bcd, tem_neg, dout_vld
  );

  modport slave (
    input  raw_vld, hum_raw, tem_raw,
    output busy, hum_bcd, tem_bcd, tem_neg, dout_vld
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble: 11-bit binary to four BCD digits, one shift per cycle.
// The start cycle itself performs the first shift straight from din, so the
// full result sits in bcd ten cycles after start and done pulses then.
module bin2bcd_seq
  import aht10_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCALE_W-1:0] din,
  output logic [BCD_W-1:0]   bcd,
  output logic               done
);

  logic [SCALE_W-1:0] sr;
  logic [CNT_W-1:0]   cnt;
  logic               active;

  logic [BCD_W-1:0]   src;
  logic [BCD_W-1:0]   adj;
  logic               bit_in;

  // Select the shift source: a fresh load on start, else the running value.
  always_comb begin
    src    = bcd;
    bit_in = sr[SCALE_W-1];
    if (start) begin
      src    = '0;
      bit_in = din[SCALE_W-1];
    end
    adj = dabble_adj(src);
  end

  // Shift/adjust register and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd    <= '0;
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd    <= {adj[BCD_W-2:0], bit_in};
        sr     <= {din[SCALE_W-2:0], 1'b0};
        cnt    <= CNT_W'(1);
        active <= 1'b1;
      end else if (active) begin
        bcd <= {adj[BCD_W-2:0], bit_in};
        sr  <= {sr[SCALE_W-2:0], 1'b0};
        cnt <= cnt + CNT_W'(1);
        if (cnt == LAST_STEP) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aht10_data_conv.sv
// AHT10 raw humidity/temperature words to BCD tenths. One serial shift-add
// multiplier and one serial double-dabble unit are shared between the two
// channels under a single sequencing FSM.
module aht10_data_conv
  import aht10_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aht10_data_conv_if.slave   bus
);

  state_t             state;
  logic [CNT_W-1:0]   step;
  logic [PROD_W-1:0]  acc;
  logic [RAW_W-1:0]   hum_r;
  logic [RAW_W-1:0]   tem_r;
  logic [HUM_W-1:0]   hum_hold;
  logic               sign_r;

  logic [SCALE_W-1:0] k_sel;
  logic [RAW_W-1:0]   mcand;
  logic [PROD_W-1:0]  pp;
  logic [SCALE_W-1:0] scaled;
  logic [SCALE_W:0]   diff;
  logic [SCALE_W:0]   ndiff;
  logic               neg;
  logic [SCALE_W-1:0] mag;
  logic               bcd_start;
  logic [SCALE_W-1:0] bcd_din;
  logic [BCD_W-1:0]   bcd_q;
  logic               bcd_done;

  // Datapath steering: partial product, offset/sign and BCD unit feed.
  always_comb begin
    k_sel  = (state == ST_MUL_T) ? K_TEM : K_HUM;
    mcand  = (state == ST_MUL_T) ? tem_r : hum_r;
    pp     = k_sel[step] ? (PROD_W'(mcand) << step) : '0;
    scaled = acc[PROD_W-1:RAW_W];
    diff   = {1'b0, scaled} - T_OFFSET;
    ndiff  = T_OFFSET - {1'b0, scaled};
    neg    = diff[SCALE_W];
    mag    = neg ? ndiff[SCALE_W-1:0] : diff[SCALE_W-1:0];
    // Temperature conversion starts in ADJ so its result lands inside BCD_T,
    // in time to be loaded into the outputs on the edge that enters DONE.
    bcd_start = ((state == ST_BCD_H) && (step == '0)) || (state == ST_ADJ);
    bcd_din   = (state == ST_ADJ) ? mag : scaled;
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .din   (bcd_din),
    .bcd   (bcd_q),
    .done  (bcd_done)
  );

  // Sequencing FSM with the shared accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      step         <= '0;
      acc          <= '0;
      hum_r        <= '0;
      tem_r        <= '0;
      hum_hold     <= '0;
      sign_r       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.dout_vld <= 1'b0;
      bus.hum_bcd  <= '0;
      bus.tem_bcd  <= '0;
      bus.tem_neg  <= 1'b0;
    end else begin
      bus.dout_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.raw_vld) begin
            hum_r    <= bus.hum_raw;
            tem_r    <= bus.tem_raw;
            acc      <= '0;
            step     <= '0;
            bus.busy <= 1'b1;
            state    <= ST_MUL_H;
          end
        end
        ST_MUL_H: begin
          acc <= acc + pp;
          if (step == LAST_STEP) begin
            step  <= '0;
            state <= ST_BCD_H;
          end else begin
            step <= step + CNT_W'(1);
          end
        end
        ST_BCD_H: begin
          if (step == LAST_STEP) begin
            step  <= '0;
            acc   <= '0;
            state <= ST_MUL_T;
          end else begin
            step <= step + CNT_W'(1);
          end
        end
        ST_MUL_T: begin
          // Humidity digits become ready during the first multiply cycle.
          if (bcd_done) hum_hold <= bcd_q[HUM_W-1:0];
          acc <= acc + pp;
          if (step == LAST_STEP) begin
            step  <= '0;
            state <= ST_ADJ;
          end else begin
            step <= step + CNT_W'(1);
          end
        end
        ST_ADJ: begin
          sign_r <= neg;
          step   <= '0;
          state  <= ST_BCD_T;
        end
        ST_BCD_T: begin
          if (step == LAST_STEP) begin
            step         <= '0;
            bus.hum_bcd  <= hum_hold;
            bus.tem_bcd  <= bcd_q;
            bus.tem_neg  <= sign_r;
            bus.dout_vld <= 1'b1;
            state        <= ST_DONE;
          end else begin
            step <= step + CNT_W'(1);
          end
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aht10_data_conv.sv
// Directed bench for aht10_data_conv: known raw words with hand-computed BCD
// results, 46-cycle latency, busy overlap handling and mid-conversion reset.
module tb_aht10_data_conv;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   vld_cnt = 0;
  int   v0;

  always #5 clk = ~clk;

  aht10_data_conv_if bus ();

  aht10_data_conv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) if (bus.dout_vld) vld_cnt++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse raw_vld for one cycle, then scramble the raw words; ends in cycle 1.
  task automatic start_conv(input logic [19:0] h, input logic [19:0] t);
    bus.hum_raw = h;
    bus.tem_raw = t;
    bus.raw_vld = 1'b1;
    tick();
    bus.raw_vld = 1'b0;
    bus.hum_raw = 20'h5A5A5;
    bus.tem_raw = 20'hA5A5A;
    check("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  // Wait (bounded) for dout_vld counting cycles from n0, then check results.
  task automatic wait_done(input int n0, input logic [11:0] eh, input logic [15:0] et,
                           input logic en);
    int n;
    n = n0;
    while (!bus.dout_vld && n < 100) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd46);
    check("hum_bcd", 32'(bus.hum_bcd), 32'(eh));
    check("tem_bcd", 32'(bus.tem_bcd), 32'(et));
    check("tem_neg", 32'(bus.tem_neg), 32'(en));
    check("busy_at_vld", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    bus.raw_vld = 1'b0;
    bus.hum_raw = '0;
    bus.tem_raw = '0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_vld", 32'(bus.dout_vld), 32'd0);
    check("rst_hum", 32'(bus.hum_bcd), 32'd0);
    check("rst_tem", 32'(bus.tem_bcd), 32'd0);
    check("rst_neg", 32'(bus.tem_neg), 32'd0);
    rst = 1'b0;
    tick();

    // Mid-scale, full-scale, zero, and the 0.0 / -0.1 degree boundary.
    tick(); start_conv(20'h80000, 20'h80000); wait_done(1, 12'h500, 16'h0500, 1'b0);
    tick(); start_conv(20'hFFFFF, 20'hFFFFF); wait_done(1, 12'h999, 16'h1499, 1'b0);
    tick(); start_conv(20'h00000, 20'h00000); wait_done(1, 12'h000, 16'h0500, 1'b1);
    tick(); start_conv(20'h12345, 20'h40000); wait_done(1, 12'h071, 16'h0000, 1'b0);
    tick(); start_conv(20'hC0000, 20'h3FFFF); wait_done(1, 12'h750, 16'h0001, 1'b1);

    // Second strobe while busy is dropped; a strobe as busy falls is taken.
    tick();
    v0 = vld_cnt;
    start_conv(20'h80000, 20'h80000);
    repeat (9) tick();
    bus.hum_raw = 20'hFFFFF;
    bus.tem_raw = 20'hFFFFF;
    bus.raw_vld = 1'b1;
    tick();
    bus.raw_vld = 1'b0;
    wait_done(11, 12'h500, 16'h0500, 1'b0);
    tick();
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("one_vld", 32'(vld_cnt - v0), 32'd1);
    start_conv(20'hC0000, 20'h3FFFF);
    wait_done(1, 12'h750, 16'h0001, 1'b1);

    // Reset 20 cycles into a conversion aborts it and clears the outputs.
    tick();
    start_conv(20'hFFFFF, 20'hFFFFF);
    repeat (19) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hum", 32'(bus.hum_bcd), 32'd0);
    check("abort_tem", 32'(bus.tem_bcd), 32'd0);
    check("abort_neg", 32'(bus.tem_neg), 32'd0);
    tick();
    rst = 1'b0;
    v0 = vld_cnt;
    repeat (60) tick();
    check("abort_no_vld", 32'(vld_cnt - v0), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);
    tick();
    start_conv(20'h33333, 20'h33333);
    wait_done(1, 12'h199, 16'h0101, 1'b1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aht10_data_conv.md
# aht10_data_conv

Converts the AHT10 raw 20-bit humidity and temperature words, delivered by the I2C read controller after each measurement, into display-ready BCD tenths: humidity 00.0–99.9 %RH and temperature −50.0…149.9 °C. It sits directly downstream of the sensor read controller and feeds the six-digit seven-segment driver. The UART reporter may also consume it. A multi-cycle serial multiply / double-dabble datapath keeps area small, since the sensor updates only every ~80 ms.

## Interface
- RAW_W, 20, raw sample width; only 20 is supported, and the scale shift equals RAW_W.

- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- raw_vld  in  1  one-cycle strobe; hum_raw/tem_raw valid
- hum_raw  in  20  AHT10 humidity word S_RH
- tem_raw  in  20  AHT10 temperature word S_T
- busy  out  1  high from accept until dout_vld cycle inclusive
- hum_bcd  out  12  three BCD digits, humidity tenths (e.g. 0x505 = 50.5 %)
- tem_bcd  out  16  four BCD digits, |temperature| tenths
- tem_neg  out  1  temperature below 0.0 °C
- dout_vld  out  1  one-cycle strobe; all result outputs updated this cycle

## Operation
- Humidity: H10 = (hum_raw × 1000) >> 20. Truncate, no rounding. Range 0…999.
- Temperature: T10 = ((tem_raw × 2000) >> 20) − 500. Range −500…1499.
  - tem_neg = (T10 < 0).
  - tem_bcd encodes |T10|.
  - Zero is positive.
- Product width is 31 bits. Keep product[30:20] (11 bits) as the scaled value.
- Multiply is serial shift-add, one bit of the 11-bit constant per cycle, LSB first: 11 cycles.
- Binary-to-BCD is serial double-dabble on the 11-bit value, one shift per cycle: 11 cycles, 16-bit BCD result.
- For humidity, the top digit is always 0 and is dropped.
- FSM states:
  - IDLE: raw_vld=1 captures both raw words and goes to MUL_H.
  - MUL_H (11 cycles) → BCD_H (11 cycles).
  - BCD_H → MUL_T (11 cycles).
  - MUL_T → ADJ (1 cycle): subtract 500, set sign, take magnitude.
  - ADJ → BCD_T (11 cycles).
  - BCD_T → DONE (1 cycle): load outputs, pulse dout_vld.
  - DONE → IDLE.
- raw_vld while busy=1 is ignored. There is no queueing, and raw words are not re-sampled.
- Result outputs hold their last value until the next DONE.

## Timing
- Accept edge = the rising edge at which IDLE samples raw_vld=1. busy rises in the following cycle.
- dout_vld is high during the 46th cycle after the accept edge (1+11+11+11+1+11 states, DONE included).
- busy falls in the cycle after dout_vld, so a new raw_vld may be accepted in that same cycle. Back-to-back conversion period is 47 cycles.
- Reset values:
  - busy=0, dout_vld=0, tem_neg=0.
  - hum_bcd=0x000, tem_bcd=0x0000.
  - FSM=IDLE; all datapath registers 0.
- Reset asserted mid-conversion aborts immediately. No dout_vld is issued, and outputs return to their reset values.
- All outputs are registered; there are no combinational paths from inputs.

## Structure
- Package aht10_pkg holds:
  - state encoding;
  - constants K_HUM=1000, K_TEM=2000, T_OFFSET=500, SCALE_W=11, BCD_W=16.
- One sub-module, bin2bcd_seq: 11-bit serial double-dabble with start/done. Instantiate it once and share it for humidity and temperature.
- The multiplier is shared the same way: one 31-bit accumulator in the top level, with the constant selected by the FSM.

## Test plan
- hum_raw=0x80000, tem_raw=0x80000, raw_vld pulse → dout_vld 46 cycles later; hum_bcd=0x500, tem_bcd=0x0500, tem_neg=0.
- hum_raw=0xFFFFF, tem_raw=0xFFFFF → hum_bcd=0x999, tem_bcd=0x1499, tem_neg=0.
- hum_raw=0x00000, tem_raw=0x00000 → hum_bcd=0x000, tem_bcd=0x0500, tem_neg=1.
- tem_raw=0x40000 → tem_bcd=0x0000, tem_neg=0. tem_raw=0x3FFFF → tem_bcd=0x0001, tem_neg=1 (truncation check).
- Second raw_vld 10 cycles after the first → ignored: exactly one dout_vld, results from the first sample. Then raw_vld in the cycle busy falls → accepted.
- rst pulse 20 cycles into a conversion → outputs 0, no dout_vld. The next conversion completes normally with correct values.
